// File: rtl/clock_gating_pkg.sv
// Shared types and default constants for the clock-gating control slice.
package clock_gating_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PREP = 2'd1,
      OFF  = 2'd2,
      WAKE = 2'd3
   } gate_state_t;

   localparam int unsigned IDLE_CYCLES_DEF = 16;
   localparam int unsigned WAKE_CYCLES_DEF = 2;
   localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// Activity/handshake bundle between the gated domain and its clock-gate controller.
//  BUSY, WAKE_REQ, FORCE_ON : activity and override requests into the controller
//  GATE_EN                  : registered enable to the gating cell
//  CLK_READY                : gated clock running and settled
//  GATED, GATE_CNT          : status and RUN->OFF transition count
interface clock_gate_ctrl_if
   import clock_gating_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic             BUSY;
   logic             WAKE_REQ;
   logic             FORCE_ON;
   logic             GATE_EN;
   logic             CLK_READY;
   logic             GATED;
   logic [CNT_W-1:0] GATE_CNT;

   // Controller side.
   modport master (
      input  BUSY, WAKE_REQ, FORCE_ON,
      output GATE_EN, CLK_READY, GATED, GATE_CNT
   );

   // Consumer/requester side.
   modport slave (
      output BUSY, WAKE_REQ, FORCE_ON,
      input  GATE_EN, CLK_READY, GATED, GATE_CNT
   );
endinterface

// File: rtl/clock_gate_ctrl.sv
// Clock-gate controller: stops the gated domain's clock after a run of idle cycles
// and restarts it on activity, with a CLK_READY warning/settle handshake.
//  CLK : free-running clock      RST : synchronous active-high reset
//  bus : clock_gate_ctrl_if.master (activity inputs, gate enable and status outputs)
module clock_gate_ctrl
   import clock_gating_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
   parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   clock_gate_ctrl_if.master  bus
);

   localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
   localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);

   if (IDLE_CYCLES == 0) begin : g_bad_idle
      $error("clock_gate_ctrl: IDLE_CYCLES must be >= 1");
   end
   if (WAKE_CYCLES == 0) begin : g_bad_wake
      $error("clock_gate_ctrl: WAKE_CYCLES must be >= 1");
   end

   gate_state_t       state_q, state_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
   logic              gate_en_q, gate_en_d;
   logic              clk_ready_q, clk_ready_d;
   logic              gated_q, gated_d;
   logic [CNT_W-1:0]  gate_cnt_q, gate_cnt_d;
   logic              idle_c;

   assign idle_c = !bus.BUSY && !bus.WAKE_REQ && !bus.FORCE_ON;

   // State, counters and output flops.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= RUN;
         idle_cnt_q  <= '0;
         wake_cnt_q  <= '0;
         gate_en_q   <= 1'b1;
         clk_ready_q <= 1'b1;
         gated_q     <= 1'b0;
         gate_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         idle_cnt_q  <= idle_cnt_d;
         wake_cnt_q  <= wake_cnt_d;
         gate_en_q   <= gate_en_d;
         clk_ready_q <= clk_ready_d;
         gated_q     <= gated_d;
         gate_cnt_q  <= gate_cnt_d;
      end
   end

   // Next state and idle/wake counters.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      case (state_q)
         RUN: begin
            if (!idle_c) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q != IDLE_W'(IDLE_CYCLES - 1)) begin
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end else begin
               state_d = PREP;
            end
         end
         PREP: begin
            // Activity during the warning cycle cancels gating; the clock never stopped.
            if (!idle_c) begin
               state_d    = RUN;
               idle_cnt_d = '0;
            end else begin
               state_d = OFF;
            end
         end
         OFF: begin
            if (!idle_c) begin
               state_d    = WAKE;
               wake_cnt_d = '0;
            end
         end
         WAKE: begin
            // Settle period runs to completion regardless of inputs.
            if (wake_cnt_q != WAKE_W'(WAKE_CYCLES - 1)) begin
               wake_cnt_d = wake_cnt_q + WAKE_W'(1);
            end else begin
               state_d    = RUN;
               idle_cnt_d = '0;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Output values for the next cycle, derived from the next state so the flops track it.
   always_comb begin
      gate_en_d   = (state_d != OFF);
      clk_ready_d = (state_d == RUN);
      gated_d     = (state_d == OFF);
      gate_cnt_d  = gate_cnt_q;
      if ((state_q == PREP) && (state_d == OFF)) begin
         gate_cnt_d = gate_cnt_q + CNT_W'(1);
      end
   end

   assign bus.GATE_EN   = gate_en_q;
   assign bus.CLK_READY = clk_ready_q;
   assign bus.GATED     = gated_q;
   assign bus.GATE_CNT  = gate_cnt_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2, CNT_W=4.
module tb_clock_gate_ctrl;

   localparam int unsigned CNT_W = 4;

   logic CLK;
   logic RST;
   int   checks;
   int   errors;
   time  last_pos;

   clock_gate_ctrl_if #(.CNT_W(CNT_W)) bus ();

   clock_gate_ctrl #(
      .IDLE_CYCLES (4),
      .WAKE_CYCLES (2),
      .CNT_W       (CNT_W)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) last_pos = $time;

   // GATE_EN may only move in the time step of a clock rising edge.
   always @(bus.GATE_EN) begin
      checks++;
      if ($time != last_pos) begin
         errors++;
         $display("FAIL gate_en_glitch: GATE_EN changed at t=%0t, last posedge t=%0t", $time, last_pos);
      end
   end

   typedef struct {
      logic             busy;
      logic             wake_req;
      logic             force_on;
      logic             ge;
      logic             rdy;
      logic             gd;
      logic [CNT_W-1:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic b, input logic w, input logic f,
                               input logic ge, input logic rdy, input logic gd,
                               input logic [CNT_W-1:0] cnt);
      vec_t v;
      v.busy = b; v.wake_req = w; v.force_on = f;
      v.ge = ge; v.rdy = rdy; v.gd = gd; v.cnt = cnt;
      vecs.push_back(v);
   endfunction

   task automatic step(input logic b, input logic w, input logic f);
      bus.BUSY     = b;
      bus.WAKE_REQ = w;
      bus.FORCE_ON = f;
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic ge, input logic rdy,
                        input logic gd, input logic [CNT_W-1:0] cnt);
      checks++;
      if (bus.GATE_EN !== ge || bus.CLK_READY !== rdy || bus.GATED !== gd || bus.GATE_CNT !== cnt) begin
         errors++;
         $display("FAIL %s: got en=%b rdy=%b gated=%b cnt=%0d, want en=%b rdy=%b gated=%b cnt=%0d",
                  name, bus.GATE_EN, bus.CLK_READY, bus.GATED, bus.GATE_CNT, ge, rdy, gd, cnt);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      last_pos = 0;
      RST      = 1'b1;

      // Idle from reset: PREP after the 4th edge, OFF after the 5th.
      add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0); add(0,0,0, 1,1,0,0);
      add(0,0,0, 1,0,0,0); add(0,0,0, 0,0,1,1); add(0,0,0, 0,0,1,1);
      // One-cycle WAKE_REQ: enable next edge, ready two edges later.
      add(0,1,0, 1,0,0,1); add(0,0,0, 1,0,0,1); add(0,0,0, 1,1,0,1);
      // Idle into PREP, then WAKE_REQ cancels gating.
      add(0,0,0, 1,1,0,1); add(0,0,0, 1,1,0,1); add(0,0,0, 1,1,0,1);
      add(0,0,0, 1,0,0,1); add(0,1,0, 1,1,0,1);
      // BUSY on the 3rd idle cycle restarts the idle count.
      add(0,0,0, 1,1,0,1); add(0,0,0, 1,1,0,1); add(1,0,0, 1,1,0,1);
      add(0,0,0, 1,1,0,1); add(0,0,0, 1,1,0,1); add(0,0,0, 1,1,0,1);
      add(0,0,0, 1,0,0,1); add(0,0,0, 0,0,1,2);
      // BUSY alone wakes; WAKE ignores inputs until done.
      add(1,0,0, 1,0,0,2); add(1,0,0, 1,0,0,2); add(0,0,0, 1,1,0,2);
      // Gate again, then FORCE_ON wakes.
      add(0,0,0, 1,1,0,2); add(0,0,0, 1,1,0,2); add(0,0,0, 1,1,0,2);
      add(0,0,0, 1,0,0,2); add(0,0,0, 0,0,1,3);
      add(0,0,1, 1,0,0,3); add(0,0,1, 1,0,0,3); add(0,0,1, 1,1,0,3);

      step(0, 0, 0);
      check("reset", 1'b1, 1'b1, 1'b0, 4'd0);
      RST = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].busy, vecs[i].wake_req, vecs[i].force_on);
         check($sformatf("vec%0d", i), vecs[i].ge, vecs[i].rdy, vecs[i].gd, vecs[i].cnt);
      end

      // FORCE_ON held: never leaves RUN.
      for (int i = 0; i < 100; i++) begin
         step(0, 0, 1);
         check("force_on_hold", 1'b1, 1'b1, 1'b0, 4'd3);
      end

      // Reset while in WAKE.
      repeat (5) step(0, 0, 0);
      check("off_before_wake_rst", 1'b0, 1'b0, 1'b1, 4'd4);
      step(0, 1, 0);
      check("in_wake", 1'b1, 1'b0, 1'b0, 4'd4);
      RST = 1'b1;
      step(0, 0, 0);
      check("rst_in_wake", 1'b1, 1'b1, 1'b0, 4'd0);
      RST = 1'b0;

      // Reset while in OFF.
      repeat (5) step(0, 0, 0);
      check("off_before_rst", 1'b0, 1'b0, 1'b1, 4'd1);
      RST = 1'b1;
      step(0, 0, 0);
      check("rst_in_off", 1'b1, 1'b1, 1'b0, 4'd0);
      RST = 1'b0;

      // 17 gate cycles: counter wraps to 1.
      repeat (5) step(0, 0, 0);
      check("wrap_gate1", 1'b0, 1'b0, 1'b1, 4'd1);
      for (int i = 2; i <= 17; i++) begin
         step(0, 1, 0);
         step(0, 0, 0);
         step(0, 0, 0);
         check("wrap_run", 1'b1, 1'b1, 1'b0, CNT_W'(i - 1));
         repeat (5) step(0, 0, 0);
         check($sformatf("wrap_gate%0d", i), 1'b0, 1'b0, 1'b1, CNT_W'(i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
